// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage.
// Latency: n/a (package only).
// Backpressure: n/a.
package fetch_pkg;

   localparam int          INSTR_BYTES      = 4;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_DISCARD,
      S_HOLD,
      S_HALTED,
      S_ERR
   } fetch_state_t;

   // Redirect targets must land on an instruction boundary.
   function automatic logic word_aligned(input logic [31:0] addr);
      return addr[1:0] == 2'b00;
   endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch stage bus: instruction-memory request/ack, decode valid/ready, redirect/halt.
// Latency: n/a (wiring only).
// Backpressure: decode stalls via instr_ready; memory stalls by withholding imem_ack.
// Optional: FETCH_PERF_CNT_EN adds retired_cnt and stall_cnt.
interface fetch_sequencer_if;
   import fetch_pkg::*;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_addr;
   logic        halt;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready;
   logic        halted;
   logic        misaligned;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] retired_cnt;
   logic [31:0] stall_cnt;
`endif

   modport master (
      output imem_req, imem_addr, instr_valid, instr, instr_pc, halted, misaligned,
      input  imem_ack, imem_rdata, redirect_valid, redirect_addr, halt, instr_ready
`ifdef FETCH_PERF_CNT_EN
      , output retired_cnt, stall_cnt
`endif
   );

   modport slave (
      input  imem_req, imem_addr, instr_valid, instr, instr_pc, halted, misaligned,
      output imem_ack, imem_rdata, redirect_valid, redirect_addr, halt, instr_ready
`ifdef FETCH_PERF_CNT_EN
      , input retired_cnt, stall_cnt
`endif
   );

endinterface

// File: rtl/fetch_addr_reg.sv
// Program counter register: load of a redirect/latched target or +4 increment.
// Latency: new value visible the cycle after load/inc.
// Backpressure: none; holds its value when neither enable is set (load wins).
module fetch_addr_reg
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [31:0] load_addr,
   input  logic        inc,
   output logic [31:0] pc
);

   // PC update: load has priority, increment wraps modulo 2^32.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc <= RESET_PC;
      end else if (load) begin
         pc <= load_addr;
      end else if (inc) begin
         pc <= pc + 32'(INSTR_BYTES);
      end
   end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: issues one fetch at a time, holds the result for decode, obeys redirect/halt.
// Latency: instr_valid the cycle after imem_ack; next request the cycle after accept (2 cycles/instr peak).
// Backpressure: one instruction held until instr_ready; no request issued while holding.
// Optional: FETCH_PERF_CNT_EN adds retired_cnt/stall_cnt performance counters.
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   fetch_sequencer_if.master bus
);

   fetch_state_t state;
   logic [31:0]  pc;
   logic [31:0]  tgt;
   logic         halt_pend;
   logic         fetch_req;
   logic         hold_valid;
   logic [31:0]  hold_instr;
   logic [31:0]  hold_pc;
   logic         halt_flag;
   logic         err_flag;
   logic         redir_bad;
   logic         pc_load;
   logic         pc_inc;
   logic [31:0]  pc_load_addr;

   assign redir_bad = bus.redirect_valid && !word_aligned(bus.redirect_addr);

   fetch_addr_reg #(.RESET_PC(RESET_PC)) u_addr (
      .clk       (clk),
      .rst       (rst),
      .load      (pc_load),
      .load_addr (pc_load_addr),
      .inc       (pc_inc),
      .pc        (pc)
   );

   // PC control: only moves when a fetch completes or a redirect is taken outside a fetch.
   always_comb begin
      pc_load      = 1'b0;
      pc_inc       = 1'b0;
      pc_load_addr = bus.redirect_addr;
      case (state)
         S_REQ: begin
            if (!bus.halt && !redir_bad && bus.imem_ack) begin
               if (bus.redirect_valid) pc_load = 1'b1;
               else                    pc_inc  = 1'b1;
            end
         end
         S_DISCARD: begin
            // A fresh redirect arriving with the ack supersedes the latched target.
            if (!bus.halt && !halt_pend && !redir_bad && bus.imem_ack) begin
               pc_load = 1'b1;
               if (!bus.redirect_valid) pc_load_addr = tgt;
            end
         end
         S_HOLD: begin
            if (!bus.halt && !redir_bad && bus.redirect_valid) pc_load = 1'b1;
         end
         default: ;
      endcase
   end

   // Sequencer FSM: priority halt > redirect > ack/accept; a request is never withdrawn.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         tgt        <= RESET_PC;
         halt_pend  <= 1'b0;
         fetch_req  <= 1'b0;
         hold_valid <= 1'b0;
         hold_instr <= 32'h0;
         hold_pc    <= 32'h0;
         halt_flag  <= 1'b0;
         err_flag   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               fetch_req <= 1'b1;
               state     <= S_REQ;
            end
            S_REQ: begin
               if (bus.halt) begin
                  if (bus.imem_ack) begin
                     fetch_req <= 1'b0;
                     halt_flag <= 1'b1;
                     state     <= S_HALTED;
                  end else begin
                     halt_pend <= 1'b1;
                     state     <= S_DISCARD;
                  end
               end else if (redir_bad) begin
                  err_flag <= 1'b1;
                  if (bus.imem_ack) fetch_req <= 1'b0;
                  state <= S_ERR;
               end else if (bus.redirect_valid) begin
                  // With ack: data dropped, new fetch starts at once from the target.
                  if (!bus.imem_ack) begin
                     tgt   <= bus.redirect_addr;
                     state <= S_DISCARD;
                  end
               end else if (bus.imem_ack) begin
                  hold_instr <= bus.imem_rdata;
                  hold_pc    <= pc;
                  hold_valid <= 1'b1;
                  fetch_req  <= 1'b0;
                  state      <= S_HOLD;
               end
            end
            S_DISCARD: begin
               // A pending halt outranks any later redirect, aligned or not.
               if (bus.halt || halt_pend) begin
                  halt_pend <= 1'b1;
                  if (bus.imem_ack) begin
                     fetch_req <= 1'b0;
                     halt_flag <= 1'b1;
                     state     <= S_HALTED;
                  end
               end else if (redir_bad) begin
                  err_flag <= 1'b1;
                  if (bus.imem_ack) fetch_req <= 1'b0;
                  state <= S_ERR;
               end else begin
                  if (bus.redirect_valid) tgt <= bus.redirect_addr;
                  if (bus.imem_ack)       state <= S_REQ;
               end
            end
            S_HOLD: begin
               if (bus.halt) begin
                  hold_valid <= 1'b0;
                  halt_flag  <= 1'b1;
                  state      <= S_HALTED;
               end else if (redir_bad) begin
                  hold_valid <= 1'b0;
                  err_flag   <= 1'b1;
                  state      <= S_ERR;
               end else if (bus.redirect_valid || bus.instr_ready) begin
                  hold_valid <= 1'b0;
                  fetch_req  <= 1'b1;
                  state      <= S_REQ;
               end
            end
            S_ERR: begin
               // An outstanding fetch must still complete before the request drops.
               if (bus.imem_ack) fetch_req <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign bus.imem_req    = fetch_req;
   assign bus.imem_addr   = pc;
   assign bus.instr_valid = hold_valid;
   assign bus.instr       = hold_instr;
   assign bus.instr_pc    = hold_pc;
   assign bus.halted      = halt_flag;
   assign bus.misaligned  = err_flag;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] retired;
   logic [31:0] stalls;
   logic        live;

   assign live = (state != S_HALTED) && (state != S_ERR);

   // Performance counters: accepted instructions and decode stall cycles, frozen once stopped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         retired <= 32'h0;
         stalls  <= 32'h0;
      end else if (live) begin
         if (state == S_HOLD && bus.instr_ready && !bus.halt && !bus.redirect_valid)
            retired <= retired + 32'h1;
         if (hold_valid && !bus.instr_ready)
            stalls <= stalls + 32'h1;
      end
   end

   assign bus.retired_cnt = retired;
   assign bus.stall_cnt   = stalls;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: transaction-level reference model plus decoupled monitor.
// Latency: n/a.
// Backpressure: bench memory inserts random ack wait states; decode ready is randomized.
module tb_fetch_sequencer;

   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic clk;
   logic rst;

   fetch_sequencer_if bus();

   fetch_sequencer #(.RESET_PC(RST_PC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks   = 0;
   int failures = 0;

   // Expected fetch addresses and delivered {pc, instr} pairs, in program order.
   logic [31:0] exp_addr_q[$];
   logic [63:0] exp_instr_q[$];

   // Reference model: what the fetch stage has in flight, what it holds, and where it goes next.
   bit          m_boot, m_dead, m_req, m_drop, m_held, m_halt_pend, m_halted, m_mis;
   logic [31:0] m_pc, m_tgt, m_retired, m_stall;

   int mem_cnt;
   int mem_wait;
   bit mem_rand;

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return 32'hA000_0001 + (a >> 2);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_boot = 1; m_dead = 0; m_req = 0; m_drop = 0; m_held = 0;
      m_halt_pend = 0; m_halted = 0; m_mis = 0;
      m_pc = RST_PC; m_tgt = RST_PC; m_retired = 0; m_stall = 0;
      exp_addr_q.delete();
      exp_instr_q.delete();
   endtask

   // One cycle of fetch-stage behaviour given this cycle's inputs.
   task automatic model_step(input logic h, input logic rv, input logic [31:0] ra,
                             input logic rdy, input logic ack);
      logic bad;
      bad = rv && (ra[1:0] != 2'b00);
      if (m_boot) begin
         m_boot = 0;
         m_req  = 1;
         exp_addr_q.push_back(m_pc);
      end else if (m_dead) begin
         if (m_req && ack) m_req = 0;
      end else if (m_req) begin
         if (h || m_halt_pend) begin
            if (ack) begin m_req = 0; m_dead = 1; m_halted = 1; end
            else m_halt_pend = 1;
         end else if (bad) begin
            m_mis = 1; m_dead = 1;
            if (ack) m_req = 0;
         end else if (rv) begin
            if (ack) begin
               m_pc = ra; m_drop = 0;
               exp_addr_q.push_back(ra);
            end else begin
               m_drop = 1; m_tgt = ra;
            end
         end else if (ack) begin
            if (m_drop) begin
               m_drop = 0; m_pc = m_tgt;
               exp_addr_q.push_back(m_pc);
            end else begin
               exp_instr_q.push_back({m_pc, mem_data(m_pc)});
               m_held = 1;
               m_pc   = m_pc + 32'd4;
               m_req  = 0;
            end
         end
      end else if (m_held) begin
         if (!rdy) m_stall++;
         if (h) begin
            m_held = 0; m_dead = 1; m_halted = 1;
         end else if (bad) begin
            m_held = 0; m_dead = 1; m_mis = 1;
         end else if (rv) begin
            m_held = 0; m_pc = ra; m_req = 1;
            exp_addr_q.push_back(ra);
         end else if (rdy) begin
            m_held = 0; m_retired++; m_req = 1;
            exp_addr_q.push_back(m_pc);
         end
      end
   endtask

   // Apply inputs for the coming edge; bench memory answers the DUT request after wait states.
   task automatic drive(input logic h, input logic rv, input logic [31:0] ra, input logic rdy);
      logic ack;
      bus.halt           = h;
      bus.redirect_valid = rv;
      bus.redirect_addr  = ra;
      bus.instr_ready    = rdy;
      ack = bus.imem_req && (mem_cnt >= mem_wait);
      bus.imem_ack   = ack;
      bus.imem_rdata = ack ? mem_data(bus.imem_addr) : $urandom;
      if (ack) begin
         mem_cnt = 0;
         if (mem_rand) mem_wait = $urandom_range(0, 3);
      end else if (bus.imem_req) begin
         mem_cnt++;
      end
      model_step(h, rv, ra, rdy, ack);
   endtask

   task automatic step(input logic h, input logic rv, input logic [31:0] ra, input logic rdy);
      @(negedge clk);
      drive(h, rv, ra, rdy);
   endtask

   task automatic rand_step();
      logic [31:0] r;
      logic        h, rv, rdy;
      r   = $urandom;
      h   = ($urandom_range(0, 299) == 0);
      rv  = ($urandom_range(0, 7) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 31) == 0) r = r | 32'h1;
      else                            r = r & 32'hFFFF_FFFC;
      step(h, rv, r, rdy);
   endtask

   // Reset (possibly mid-operation), check reset values, release and drive cycle 0.
   task automatic start_test(input int w, input bit rnd);
      @(negedge clk);
      rst = 1'b1;
      bus.halt = 0; bus.redirect_valid = 0; bus.redirect_addr = 0;
      bus.instr_ready = 0; bus.imem_ack = 0; bus.imem_rdata = 0;
      #1;
      check("rst_imem_req",    32'(bus.imem_req),    32'h0);
      check("rst_imem_addr",   bus.imem_addr,        RST_PC);
      check("rst_instr_valid", 32'(bus.instr_valid), 32'h0);
      check("rst_instr",       bus.instr,            32'h0);
      check("rst_instr_pc",    bus.instr_pc,         32'h0);
      check("rst_halted",      32'(bus.halted),      32'h0);
      check("rst_misaligned",  32'(bus.misaligned),  32'h0);
`ifdef FETCH_PERF_CNT_EN
      check("rst_retired_cnt", bus.retired_cnt,      32'h0);
      check("rst_stall_cnt",   bus.stall_cnt,        32'h0);
`endif
      @(negedge clk);
      model_reset();
      mem_cnt  = 0;
      mem_wait = w;
      mem_rand = rnd;
      rst = 1'b0;
      drive(0, 0, 32'h0, 0);
   endtask

   task automatic end_test();
      @(posedge clk);
      #2;
      check("addr_q_drained",  exp_addr_q.size(),  32'h0);
      check("instr_q_drained", exp_instr_q.size(), 32'h0);
`ifdef FETCH_PERF_CNT_EN
      check("retired_cnt", bus.retired_cnt, m_retired);
      check("stall_cnt",   bus.stall_cnt,   m_stall);
`endif
   endtask

   // Monitor: per-cycle status against the model, pops the scoreboard on each new request/instruction.
   bit          last_req, last_valid;
   logic [31:0] last_addr, last_instr, last_ipc;
   logic [63:0] mon_e;

   initial begin
      last_req = 0; last_valid = 0;
      last_addr = 0; last_instr = 0; last_ipc = 0;
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            last_req   = 0;
            last_valid = 0;
         end else begin
            check("imem_req",    32'(bus.imem_req),    32'(m_req));
            check("instr_valid", 32'(bus.instr_valid), 32'(m_held));
            check("halted",      32'(bus.halted),      32'(m_halted));
            check("misaligned",  32'(bus.misaligned),  32'(m_mis));
            if (bus.imem_req) begin
               if (!last_req || bus.imem_ack) begin
                  if (exp_addr_q.size() == 0) begin
                     checks++; failures++;
                     $display("FAIL unexpected_req actual=%h required=none at %0t", bus.imem_addr, $time);
                  end else begin
                     check("imem_addr", bus.imem_addr, exp_addr_q.pop_front());
                  end
               end else begin
                  check("imem_addr_stable", bus.imem_addr, last_addr);
               end
            end
            if (bus.instr_valid) begin
               if (!last_valid) begin
                  if (exp_instr_q.size() == 0) begin
                     checks++; failures++;
                     $display("FAIL unexpected_instr actual=%h required=none at %0t", bus.instr, $time);
                  end else begin
                     mon_e = exp_instr_q.pop_front();
                     check("instr_pc", bus.instr_pc, mon_e[63:32]);
                     check("instr",    bus.instr,    mon_e[31:0]);
                  end
               end else begin
                  check("instr_stable",    bus.instr,    last_instr);
                  check("instr_pc_stable", bus.instr_pc, last_ipc);
               end
            end
            last_req   = bus.imem_req;
            last_addr  = bus.imem_addr;
            last_valid = bus.instr_valid;
            last_instr = bus.instr;
            last_ipc   = bus.instr_pc;
         end
      end
   end

   initial begin
      rst = 1'b1;
      bus.halt = 0; bus.redirect_valid = 0; bus.redirect_addr = 0;
      bus.instr_ready = 0; bus.imem_ack = 0; bus.imem_rdata = 0;
      mem_cnt = 0; mem_wait = 0; mem_rand = 0;
      model_reset();

      // Zero-wait memory, two fetches, then three stall cycles in HOLD.
      start_test(0, 0);
      step(0, 0, 32'h0, 0);
      step(0, 0, 32'h0, 1);
      step(0, 0, 32'h0, 0);
      repeat (3) step(0, 0, 32'h0, 0);
      step(0, 0, 32'h0, 1);
      end_test();
`ifdef FETCH_PERF_CNT_EN
      check("t1_stall_cnt",   bus.stall_cnt,   32'd3);
      check("t1_retired_cnt", bus.retired_cnt, 32'd2);
`endif

      // Redirect to 0x100 while the first fetch waits two cycles for ack.
      start_test(2, 0);
      step(0, 0, 32'h0,   1);
      step(0, 1, 32'h100, 1);
      repeat (10) step(0, 0, 32'h0, 1);
      end_test();

      // Same-cycle halt and redirect in HOLD, later redirects ignored.
      start_test(0, 0);
      step(0, 0, 32'h0,   0);
      step(1, 1, 32'h200, 0);
      repeat (8) step(0, 1, 32'h300, 1);
      end_test();
      check("t3_halted", 32'(bus.halted), 32'h1);

      // Misaligned redirect from HOLD.
      start_test(0, 0);
      step(0, 0, 32'h0,   0);
      step(0, 1, 32'h102, 1);
      repeat (8) step(0, 1, 32'h40, 1);
      end_test();
      check("t4_misaligned", 32'(bus.misaligned), 32'h1);

      // Misaligned redirect while a fetch is outstanding: request held until its ack.
      start_test(3, 0);
      step(0, 0, 32'h0,   1);
      step(0, 1, 32'h102, 1);
      repeat (8) step(0, 0, 32'h0, 1);
      end_test();

      // Redirect to the top word, accept, PC wraps to zero.
      start_test(0, 0);
      step(0, 0, 32'h0,         0);
      step(0, 1, 32'hFFFF_FFFC, 1);
      step(0, 0, 32'h0,         0);
      step(0, 0, 32'h0,         1);
      step(0, 0, 32'h0,         0);
      step(0, 0, 32'h0,         1);
      end_test();

      // Randomized traffic, each run ending in a reset with work possibly in flight.
      for (int run = 0; run < 20; run++) begin
         start_test($urandom_range(0, 3), 1);
         repeat (250) rand_step();
         end_test();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Fetch-stage controller for the miniRISC core: owns the instruction address register and sequences every instruction fetch over a request/acknowledge handshake to instruction memory. It hands fetched instructions to decode with a valid/ready handshake and accepts redirects (taken branches, jumps) from execute. It also handles halt and misaligned-target errors. It replaces free-running PC updates with a stall- and redirect-aware schedule.

## Interface
- RESET_PC, 32'h0000_0000, address of the first fetch after reset
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  32  fetch address, word aligned
- imem_ack  in  1  memory has returned data for the current request
- imem_rdata  in  32  instruction word, valid when imem_ack=1
- redirect_valid  in  1  execute requests PC redirect
- redirect_addr  in  32  redirect target
- halt  in  1  halt instruction retired
- instr_valid  out  1  instr/instr_pc hold a fetched instruction
- instr  out  32  instruction word
- instr_pc  out  32  address instr was fetched from
- instr_ready  in  1  decode accepts instr this cycle
- halted  out  1  sequencer stopped by halt
- misaligned  out  1  sticky error: redirect target not word aligned
- retired_cnt  out  32  instructions accepted by decode (only with FETCH_PERF_CNT_EN)
- stall_cnt  out  32  cycles with instr_valid=1 and instr_ready=0 (only with FETCH_PERF_CNT_EN)

## Operation
- States: IDLE, REQ, DISCARD, HOLD, HALTED, ERR.
- IDLE: entered only from reset; goes to REQ unconditionally after one cycle.
- REQ: imem_req=1, imem_addr=pc, both stable until imem_ack.
  - On ack: instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+4, go to HOLD.
- A request, once issued, must never be withdrawn. If redirect or halt arrives in REQ without ack, latch it and go to DISCARD.
  - A redirect with ack in the same cycle also discards the returned data.
- DISCARD: imem_req stays 1 at the old address. On ack, data is dropped.
  - Pending halt: go to HALTED.
  - Otherwise: pc<=latched target, go to REQ.
- HOLD: instr_valid=1, imem_req=0.
  - instr_ready=1: instr_valid<=0, go to REQ using the already-incremented pc.
- Priority among same-cycle events: halt > redirect > instr_ready/imem_ack.
  - Redirect in HOLD: instr_valid<=0, pc<=redirect_addr, go to REQ. The held instruction is not counted as accepted.
  - Halt in HOLD: instr_valid<=0, go to HALTED.
- Redirect with redirect_addr[1:0]!=0: misaligned<=1, instr_valid<=0, go to ERR. This applies even during DISCARD.
- HALTED and ERR: terminal until rst. imem_req=0, instr_valid=0, and all inputs are ignored.
  - If a request is outstanding when a misaligned redirect arrives, ERR waits for its ack before dropping imem_req.
- Arithmetic: pc+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000 with no flag.
- Reset mid-operation: outstanding request is abandoned, and memory must tolerate a dropped request.

## Timing
- Reset values:
  - Outputs: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, halted=0, misaligned=0, counters=0.
  - Internal: pc=RESET_PC, state=IDLE.
- Cycle 0 is the first edge after rst deasserts: IDLE→REQ. imem_req is high during cycle 1.
- Ack in cycle N: instr_valid high from cycle N+1.
- Accept in cycle M: next imem_req high in cycle M+1.
- Peak throughput is one instruction per 2 cycles with zero-wait memory.
- halted and misaligned assert the cycle after the transition edge.
- imem_req and imem_addr are registered/state-decoded, with no combinational path from imem_ack.

## Configuration
- FETCH_PERF_CNT_EN defined: retired_cnt and stall_cnt are present.
  - Both are 32-bit counters that wrap, reset to 0, and freeze in HALTED/ERR.
- Undefined: both ports and counters are absent. All other behaviour is identical.

## Structure
- Shared package fetch_pkg:
  - state enum
  - INSTR_BYTES=4
  - default RESET_PC
- One sub-module, fetch_addr_reg: pc register with async reset to RESET_PC, load of redirect/latched target, and +4 increment enable.

## Test plan
- Reset release, zero-wait memory returning 32'hA0000001 and 32'hA0000002:
  - imem_addr 0 then 4.
  - instr_pc 0 then 4.
  - instr_valid high cycles 2 and 4.
- instr_ready low 3 cycles in HOLD → instr and instr_pc stable, no imem_req, stall_cnt=3 (macro on).
- Redirect to 32'h100 while REQ waits 2 cycles for ack:
  - The ack data is never presented.
  - Next imem_addr=32'h100.
  - retired_cnt unchanged.
- Same-cycle halt and redirect in HOLD:
  - halted=1 next cycle, imem_req stays 0 forever.
  - A later redirect is ignored.
- Redirect to 32'h102 → misaligned=1, instr_valid=0, no further requests until rst.
- Redirect to 32'hFFFF_FFFC, accept → next imem_addr=32'h0000_0000.
